// File: rtl/vga_frame_reader.sv
// Frame-buffer reader for a VGA pipeline: maps screen col/row to an upscaled image address,
// looks up greyscale pixels and emits RGB444 with hsync/vsync delayed to match (2 pixel periods).
module vga_frame_reader #(
  parameter int unsigned c_img_cols   = 160,
  parameter int unsigned c_img_rows   = 120,
  parameter int unsigned c_scale_log2 = 1,
  parameter int unsigned c_img_col0   = 0,
  parameter int unsigned c_img_row0   = 0,
  parameter logic [11:0] c_bg_color   = 12'h000,
  parameter logic        c_synch_act  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_pxl,
  input  logic        visible_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  col,
  input  logic [9:0]  row,
  output logic [14:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        img_done
);

  localparam int unsigned c_col_end  = c_img_col0 + (c_img_cols << c_scale_log2);
  localparam int unsigned c_row_end  = c_img_row0 + (c_img_rows << c_scale_log2);
  localparam logic [9:0]  c_last_col = 10'(c_col_end - 1);
  localparam logic [9:0]  c_last_row = 10'(c_row_end - 1);

  logic        in_img, is_last;
  logic [9:0]  col_off, row_off;
  logic [14:0] addr_next;

  // Stage-1 copies of the sync generator flags.
  logic in_img_q, visible_q, hsync_q, vsync_q;

  // Only the top nibble of the grey level is displayed.
  logic unused_lsbs;
  assign unused_lsbs = ^mem_data[3:0];

  always_comb begin
    in_img  = visible_in
              && (32'(col) >= c_img_col0) && (32'(col) < c_col_end)
              && (32'(row) >= c_img_row0) && (32'(row) < c_row_end);
    is_last = in_img && (col == c_last_col) && (row == c_last_row);
    col_off   = '0;
    row_off   = '0;
    addr_next = mem_addr;
    // Offsets are only formed inside the image so they can never wrap into the address.
    if (in_img) begin
      col_off   = col - 10'(c_img_col0);
      row_off   = row - 10'(c_img_row0);
      addr_next = 15'(32'(row_off >> c_scale_log2) * c_img_cols
                      + 32'(col_off >> c_scale_log2));
    end
  end

  // NOTE: all state uses non-blocking assignments so both stages read pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_img_q  <= 1'b0;
      visible_q <= 1'b0;
      hsync_q   <= ~c_synch_act;
      vsync_q   <= ~c_synch_act;
      mem_addr  <= '0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      hsync     <= ~c_synch_act;
      vsync     <= ~c_synch_act;
    end else if (new_pxl) begin
      in_img_q  <= in_img;
      visible_q <= visible_in;
      hsync_q   <= hsync_in;
      vsync_q   <= vsync_in;
      mem_addr  <= addr_next;
      if (in_img_q) begin
        {red, green, blue} <= {3{mem_data[7:4]}};
      end else if (visible_q) begin
        {red, green, blue} <= c_bg_color;
      end else begin
        {red, green, blue} <= '0;
      end
      hsync <= hsync_q;
      vsync <= vsync_q;
    end
  end

  // Self-clearing: high only for the clk after the last image pixel is captured.
  always_ff @(posedge clk) begin
    if (!rst) begin
      img_done <= 1'b0;
    end else begin
      img_done <= new_pxl && is_last;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Randomised and directed bench for vga_frame_reader against a frame-level reference model
// (address from image geometry, output = previous pixel's colour and syncs).
module tb_vga_frame_reader;

  localparam int          c_cols = 160;
  localparam int          c_rows = 120;
  localparam int          c_s    = 1;
  localparam int          c_col0 = 0;
  localparam int          c_row0 = 0;
  localparam logic [11:0] c_bg   = 12'h00F;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        new_pxl = 1'b0;
  logic        visible_in = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [9:0]  col = '0;
  logic [9:0]  row = '0;
  logic [7:0]  mem_data;
  logic [14:0] mem_addr;
  logic        hsync, vsync, img_done;
  logic [3:0]  red, green, blue;

  logic [7:0]  mem [0:32767];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [14:0] m_addr;
  logic [13:0] m_out;
  // Expected / observed values after the capture edge, and one clk later.
  logic [13:0] e_out, o_out, h_out;
  logic [14:0] e_addr, o_addr, h_addr;
  logic        e_done, o_done, h_done;

  vga_frame_reader #(
    .c_img_cols(c_cols), .c_img_rows(c_rows), .c_scale_log2(c_s),
    .c_img_col0(c_col0), .c_img_row0(c_row0), .c_bg_color(c_bg), .c_synch_act(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .new_pxl(new_pxl), .visible_in(visible_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .col(col), .row(row),
    .mem_addr(mem_addr), .mem_data(mem_data), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue), .img_done(img_done)
  );

  always #10 clk = ~clk;

  // Frame buffer with one clk read latency.
  always @(posedge clk) mem_data <= mem[mem_addr];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_addr = '0;
    m_out  = {12'h000, 1'b1, 1'b1};
  endtask

  // Presents one pixel for one pixel period (2 clk) and updates the model.
  task automatic drive_pixel(input logic [9:0] c, input logic [9:0] r,
                             input logic v, input logic hs, input logic vs);
    int  ci, ri, w, h;
    logic in;
    ci = int'(c);
    ri = int'(r);
    w  = c_cols * (2 ** c_s);
    h  = c_rows * (2 ** c_s);
    col = c; row = r; visible_in = v; hsync_in = hs; vsync_in = vs;
    new_pxl = 1'b1;
    @(negedge clk);
    new_pxl = 1'b0;
    in = v && ci >= c_col0 && ci < c_col0 + w && ri >= c_row0 && ri < c_row0 + h;
    e_out = m_out;
    if (in) m_addr = 15'(((ri - c_row0) / (2 ** c_s)) * c_cols + (ci - c_col0) / (2 ** c_s));
    e_addr = m_addr;
    e_done = in && ci == c_col0 + w - 1 && ri == c_row0 + h - 1;
    if (in)     m_out = {{3{mem[m_addr][7:4]}}, hs, vs};
    else if (v) m_out = {c_bg, hs, vs};
    else        m_out = {12'h000, hs, vs};
    o_out = {red, green, blue, hsync, vsync};
    o_addr = mem_addr;
    o_done = img_done;
    @(negedge clk);
    h_out = {red, green, blue, hsync, vsync};
    h_addr = mem_addr;
    h_done = img_done;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    new_pxl = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if ({red, green, blue} !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h expected 000", {red, green, blue}); end
    n_tests++; if ({hsync, vsync} !== 2'b11) begin n_fail++; $display("FAIL reset_sync: got %b expected 11", {hsync, vsync}); end
    n_tests++; if (mem_addr !== 15'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
    n_tests++; if (img_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", img_done); end
    new_pxl = 1'b0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_directed();
    mem[0] = 8'hA5;
    drive_pixel(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    n_tests++; if (o_addr !== 15'd0) begin n_fail++; $display("FAIL dir_addr0: got %0d expected 0", o_addr); end
    drive_pixel(10'd3, 10'd5, 1'b1, 1'b1, 1'b1);
    n_tests++; if (o_out !== {12'hAAA, 2'b11}) begin n_fail++; $display("FAIL dir_rgb_a5: got %h expected %h", o_out, {12'hAAA, 2'b11}); end
    n_tests++; if (o_addr !== 15'd321) begin n_fail++; $display("FAIL dir_addr321: got %0d expected 321", o_addr); end
    drive_pixel(10'd320, 10'd10, 1'b1, 1'b1, 1'b1);
    n_tests++; if (o_addr !== 15'd321) begin n_fail++; $display("FAIL dir_addr_hold: got %0d expected 321", o_addr); end
    n_tests++; if (o_out !== e_out) begin n_fail++; $display("FAIL dir_rgb_321: got %h expected %h", o_out, e_out); end
    drive_pixel(10'd319, 10'd239, 1'b1, 1'b1, 1'b1);
    n_tests++; if (o_out !== {12'h00F, 2'b11}) begin n_fail++; $display("FAIL dir_bg: got %h expected %h", o_out, {12'h00F, 2'b11}); end
    n_tests++; if (o_addr !== 15'd19199) begin n_fail++; $display("FAIL dir_addr_last: got %0d expected 19199", o_addr); end
    n_tests++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL dir_done_pulse: got %b expected 1", o_done); end
    n_tests++; if (h_done !== 1'b0) begin n_fail++; $display("FAIL dir_done_clear: got %b expected 0", h_done); end
    drive_pixel(10'd0, 10'd490, 1'b0, 1'b1, 1'b1);
    n_tests++; if (o_out !== e_out) begin n_fail++; $display("FAIL dir_rgb_last: got %h expected %h", o_out, e_out); end
    n_tests++; if (o_addr !== 15'd19199) begin n_fail++; $display("FAIL dir_addr_blank: got %0d expected 19199", o_addr); end
  endtask

  task automatic test_sync_latency();
    logic [5:0] hs_seq;
    hs_seq = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      drive_pixel(10'(650 + i), 10'd100, 1'b0, hs_seq[i], ~hs_seq[i]);
      n_tests++; if (o_out !== e_out) begin n_fail++; $display("FAIL sync_step%0d: got %h expected %h", i, o_out, e_out); end
      n_tests++; if (h_out !== o_out) begin n_fail++; $display("FAIL sync_hold%0d: got %h expected %h", i, h_out, o_out); end
    end
  endtask

  task automatic test_random();
    logic [9:0] c, r;
    for (int i = 0; i < 400; i++) begin
      if (i % 60 == 59) begin
        c = 10'd319; r = 10'd239;
      end else if ($urandom_range(0, 1) == 1) begin
        c = 10'($urandom_range(0, 319)); r = 10'($urandom_range(0, 239));
      end else begin
        c = 10'($urandom_range(0, 799)); r = 10'($urandom_range(0, 524));
      end
      drive_pixel(c, r, (c < 10'd640) && (r < 10'd480), 1'($urandom), 1'($urandom));
      n_tests++; if (o_out !== e_out) begin n_fail++; $display("FAIL rand_out[%0d]: got %h expected %h", i, o_out, e_out); end
      n_tests++; if (o_addr !== e_addr) begin n_fail++; $display("FAIL rand_addr[%0d]: got %0d expected %0d", i, o_addr, e_addr); end
      n_tests++; if (o_done !== e_done) begin n_fail++; $display("FAIL rand_done[%0d]: got %b expected %b", i, o_done, e_done); end
      n_tests++; if ({h_out, h_addr, h_done} !== {o_out, o_addr, 1'b0}) begin n_fail++; $display("FAIL rand_hold[%0d]: got %h expected %h", i, {h_out, h_addr, h_done}, {o_out, o_addr, 1'b0}); end
    end
  endtask

  task automatic test_reset_midline();
    for (int i = 0; i < 4; i++) mem[i] = 8'hF0;
    for (int i = 0; i < 4; i++) drive_pixel(10'(2 * i), 10'd0, 1'b1, 1'b0, 1'b0);
    n_tests++; if (o_out !== {12'hFFF, 2'b00}) begin n_fail++; $display("FAIL mid_pre: got %h expected %h", o_out, {12'hFFF, 2'b00}); end
    rst = 1'b0;
    new_pxl = 1'b1;
    @(negedge clk);
    n_tests++; if ({red, green, blue, hsync, vsync} !== {12'h000, 2'b11}) begin n_fail++; $display("FAIL mid_rst_out: got %h expected %h", {red, green, blue, hsync, vsync}, {12'h000, 2'b11}); end
    n_tests++; if (mem_addr !== 15'd0) begin n_fail++; $display("FAIL mid_rst_addr: got %0d expected 0", mem_addr); end
    rst = 1'b1;
    new_pxl = 1'b0;
    model_reset();
    @(negedge clk);
    drive_pixel(10'd2, 10'd0, 1'b1, 1'b0, 1'b0);
    n_tests++; if (o_out !== {12'h000, 2'b11}) begin n_fail++; $display("FAIL mid_black1: got %h expected %h", o_out, {12'h000, 2'b11}); end
    drive_pixel(10'd4, 10'd0, 1'b1, 1'b0, 1'b0);
    n_tests++; if (o_out !== {12'hFFF, 2'b00}) begin n_fail++; $display("FAIL mid_resume: got %h expected %h", o_out, {12'hFFF, 2'b00}); end
    n_tests++; if (o_addr !== 15'd2) begin n_fail++; $display("FAIL mid_addr: got %0d expected 2", o_addr); end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
    model_reset();
    @(negedge clk);
    test_reset();
    test_directed();
    test_sync_latency();
    test_random();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
VGA_FRAME_READER -- requirements
Module: vga_frame_reader

Interface
REQ-001 SHALL have parameter c_img_cols, 160, image width in stored pixels.
REQ-002 SHALL have parameter c_img_rows, 120, image height in stored pixels.
REQ-003 SHALL have parameter c_scale_log2, 1, display upscaling exponent (each stored pixel shown as 2^s x 2^s screen pixels).
REQ-004 SHALL have parameter c_img_col0, 0, screen column of image top-left.
REQ-005 SHALL have parameter c_img_row0, 0, screen row of image top-left.
REQ-006 SHALL have parameter c_bg_color, 12'h000, RGB444 colour for visible pixels outside the image.
REQ-007 SHALL have parameter c_synch_act, 0, active level of hsync/vsync.
REQ-008 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-009 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-010 SHALL have port new_pxl  input  1  pixel-rate enable from the sync generator, high 1 of every 2 clk.
REQ-011 SHALL have port visible_in  input  1  sync generator visible flag.
REQ-012 SHALL have port hsync_in  input  1  sync generator hsync.
REQ-013 SHALL have port vsync_in  input  1  sync generator vsync.
REQ-014 SHALL have port col  input  10  current screen column.
REQ-015 SHALL have port row  input  10  current screen row.
REQ-016 SHALL have port mem_addr  output  15  frame-buffer read address, registered.
REQ-017 SHALL have port mem_data  input  8  greyscale frame-buffer data, valid 1 clk after mem_addr.
REQ-018 SHALL have port hsync  output  1  aligned hsync to monitor.
REQ-019 SHALL have port vsync  output  1  aligned vsync to monitor.
REQ-020 SHALL have port red, green, blue  output  4 each  pixel colour.
REQ-021 SHALL have port img_done  output  1  one-clk pulse, last image address issued this frame.

Function
REQ-022 SHALL advance all pipeline registers only on clk edges where new_pxl=1 (except img_done clear, REQ-029).
REQ-023 Stage 1 SHALL register: in_img, visible_in, hsync_in, vsync_in, and mem_addr from current col/row.
REQ-024 in_img SHALL be 1 iff visible_in=1 and c_img_col0 <= col < c_img_col0+(c_img_cols<<s) and c_img_row0 <= row < c_img_row0+(c_img_rows<<s).
REQ-025 When in_img, mem_addr SHALL equal ((row-c_img_row0)>>s)*c_img_cols + ((col-c_img_col0)>>s); otherwise mem_addr SHALL hold its previous value.
REQ-026 Stage 2 SHALL register red/green/blue from mem_data[7:4] on all three channels when stage-1 in_img=1; c_bg_color when stage-1 visible=1 and in_img=0; 0 when stage-1 visible=0.
REQ-027 Stage 2 SHALL register hsync/vsync from stage-1 copies; total sync-to-output latency SHALL be exactly 2 pixel periods, identical for colour and syncs.
REQ-028 mem_data SHALL be sampled 2 clk after mem_addr update (1 clk memory latency plus margin); no other memory handshake exists.
REQ-029 img_done SHALL be 1 for exactly one clk, the clk following the stage-1 update whose captured col/row are last image column and last image row; cleared on next clk regardless of new_pxl.
REQ-030 Arithmetic SHALL be unsigned; subtractions evaluated only when in_img region test passes (no wrap into address).
REQ-031 Non-visible lines (row >= 480) SHALL yield black output and hold mem_addr.

Reset
REQ-032 While rst=0 at a clk edge: mem_addr=0, red/green/blue=0, img_done=0, hsync=vsync=~c_synch_act, all stage-1 flags=0, stage-1 syncs=~c_synch_act.
REQ-033 Reset mid-frame SHALL take priority over new_pxl; after release output resumes with 2-pixel latency, first two pixel periods black with inactive syncs.

Verification
REQ-034 Defaults, col=0,row=0,visible_in=1,mem_data=8'hA5 -> mem_addr=0, RGB=A,A,A two pixel periods after capture.
REQ-035 col=3,row=5 (s=1) -> mem_addr=2*160+1=321; col=319,row=239 -> mem_addr=19199, img_done pulse 1 clk.
REQ-036 col=320,row=10,visible_in=1, c_bg_color=12'h00F -> RGB=0,0,F, mem_addr unchanged from prior value.
REQ-037 hsync_in falls at pixel N -> hsync falls exactly 2 pixel periods (4 clk) later, aligned with colour of pixel N.
REQ-038 rst=0 asserted mid-line with RGB=F,F,F and hsync active -> next clk RGB=0, hsync=vsync=1, mem_addr=0; rst released -> 2 black pixel periods then normal.
